if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 20 ++
 rtl/if_stage.sv | 85 ++++++++
 2 files changed

// File: rtl/if_stage_pkg.sv
// Shared fetch/decode interface widths, boot/exception vectors and bus layouts.
package if_stage_pkg;
  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int BR_BUS_WD       = 33;

  localparam logic [31:0] RESET_VEC   = 32'hbfc00000;
  localparam logic [31:0] EX_VEC      = 32'hbfc00380;
  localparam logic [4:0]  EXCODE_ADEL = 5'h04;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  typedef struct packed {
    logic        ex;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;
endpackage

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF next-pc select, one-cycle SRAM fetch, stall buffer and redirects.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       ex_from_ws,
  input  logic                       eret_from_ws,
  input  logic [31:0]                cp0_epc
);
  br_bus_t     br;
  fs_to_ds_t   fs_bus;
  logic        fs_valid, fs_ex, br_pend_valid, inst_buf_valid;
  logic [31:0] fs_pc, br_pend, inst_buf, nextpc, inst;
  logic        flush, fs_allowin, misaligned;

  assign br    = br_bus;
  assign flush = ex_from_ws | eret_from_ws;

  // A flush must be able to refill even while decode is stalled, so the
  // redirected fetch is issued in the flush cycle itself.
  assign fs_allowin = !fs_valid || ds_allowin || flush;

  always_comb begin
    nextpc = fs_pc + 32'd4;
    if (ex_from_ws)         nextpc = EX_VEC;
    else if (eret_from_ws)  nextpc = cp0_epc;
    else if (br_pend_valid) nextpc = br_pend;
    else if (br.taken)      nextpc = br.target;
  end

  assign misaligned      = nextpc[1:0] != 2'b00;
  assign inst_sram_en    = !reset && fs_allowin && !misaligned;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign inst           = fs_ex ? 32'h0 : (inst_buf_valid ? inst_buf : inst_sram_rdata);
  assign fs_to_ds_valid = fs_valid && !flush;
  assign fs_bus         = '{ex: fs_ex, inst: inst, pc: fs_pc};
  assign fs_to_ds_bus   = fs_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid       <= 1'b0;
      fs_pc          <= RESET_VEC - 32'd4;
      fs_ex          <= 1'b0;
      br_pend_valid  <= 1'b0;
      br_pend        <= 32'h0;
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else begin
      if (fs_allowin) begin
        fs_valid <= 1'b1;
        fs_pc    <= nextpc;
        fs_ex    <= misaligned;
      end

      // A pending branch is consumed by the first fetch that can issue.
      if (flush || fs_allowin) begin
        br_pend_valid <= 1'b0;
      end else if (br.taken) begin
        br_pend_valid <= 1'b1;
        br_pend       <= br.target;
      end

      // SRAM data is only valid the cycle after the request; hold it while stalled.
      if (flush || (fs_to_ds_valid && ds_allowin)) begin
        inst_buf_valid <= 1'b0;
      end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
        inst_buf_valid <= 1'b1;
        inst_buf       <= inst_sram_rdata;
      end
    end
  end
endmodule
